pc_ras_unit: RTL and testbench

- Parametrised program-counter unit for the pipelined RISC core's fetch stage, replacing the plain enable-load PC register.
- Generates the next fetch address itself: sequential increment, branch redirect, and call/return through an internal circular return-address stack (RAS).
- Stall is supported via En.
- Feeds instruction-memory address; control inputs come from decode/execute.

---
 rtl/pc_ras_unit.sv | 119 +++++++++++
 tb/tb_pc_ras_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: fetch-stage program counter with branch redirect and a circular
// return-address stack for call/return.
// Optional build macro PC_TRAP_EN: when defined, a call into a full stack or a
// return from an empty stack redirects the PC to TRAP_VECTOR instead of
// overwriting the oldest entry / falling through.
module pc_ras_unit #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 4
`ifdef PC_TRAP_EN
  , parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(8'hF0)
`endif
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         En,
  input  logic                         Branch_take,
  input  logic                         Call,
  input  logic                         Ret,
  input  logic [WIDTH-1:0]             Target,
  input  logic                         Err_clr,
  output logic [WIDTH-1:0]             Data_out,
  output logic [$clog2(RAS_DEPTH):0]   Ras_count,
  output logic                         Ras_full,
  output logic                         Ras_empty,
  output logic                         Err_ovf,
  output logic                         Err_unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_nxt, pc_inc, ret_addr;
  logic [PW-1:0]    wp_q, wp_nxt, wp_top;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             ovf_q, unf_q, ovf_set, unf_set, push;
  logic [WIDTH-1:0] stack [RAS_DEPTH];

  // wp points at the next free slot; the top of stack is one below it (mod depth)
  assign pc_inc   = pc_q + STEP_W;
  assign wp_top   = wp_q - PW'(1);
  assign ret_addr = stack[wp_top];

  assign Data_out  = pc_q;
  assign Ras_count = cnt_q;
  assign Ras_full  = (cnt_q == DEPTH_C);
  assign Ras_empty = (cnt_q == '0);
  assign Err_ovf   = ovf_q;
  assign Err_unf   = unf_q;

  // next-PC and stack-pointer selection: branch > call > return > sequential
  always_comb begin
    pc_nxt  = pc_inc;
    wp_nxt  = wp_q;
    cnt_nxt = cnt_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (Branch_take) begin
      pc_nxt = Target;
    end else if (Call) begin
      if (Ras_full) begin
        ovf_set = 1'b1;
`ifdef PC_TRAP_EN
        pc_nxt  = TRAP_VECTOR;
`else
        // circular overwrite of the oldest entry; count saturates at depth
        pc_nxt  = Target;
        push    = 1'b1;
        wp_nxt  = wp_q + PW'(1);
`endif
      end else begin
        pc_nxt  = Target;
        push    = 1'b1;
        wp_nxt  = wp_q + PW'(1);
        cnt_nxt = cnt_q + CW'(1);
      end
    end else if (Ret) begin
      if (Ras_empty) begin
        unf_set = 1'b1;
`ifdef PC_TRAP_EN
        pc_nxt  = TRAP_VECTOR;
`endif
      end else begin
        pc_nxt  = ret_addr;
        wp_nxt  = wp_top;
        cnt_nxt = cnt_q - CW'(1);
      end
    end
  end

  // PC, stack pointer, count and sticky error flags; everything holds while stalled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_VECTOR;
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (En) begin
      pc_q  <= pc_nxt;
      wp_q  <= wp_nxt;
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_set | (ovf_q & ~Err_clr);
      unf_q <= unf_set | (unf_q & ~Err_clr);
    end
  end

  // stack storage carries no reset; only entries below the count are ever read
  always_ff @(posedge CLK) begin
    if (En && push) begin
      stack[wp_q] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit (WIDTH=8, STEP=1, RESET_VECTOR=0, RAS_DEPTH=4).
// Expected values follow the trap variant when PC_TRAP_EN is defined.
module tb_pc_ras_unit;

`ifdef PC_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N, En, Branch_take, Call, Ret, Err_clr;
  logic [7:0] Target;
  logic [7:0] Data_out;
  logic [2:0] Ras_count;
  logic       Ras_full, Ras_empty, Err_ovf, Err_unf;

  int n_chk  = 0;
  int n_fail = 0;
  int step_id = 0;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
    int         id;
  } exp_t;

  exp_t exp_q[$];

  pc_ras_unit #(
    .WIDTH(8), .STEP(1), .RESET_VECTOR(8'h00), .RAS_DEPTH(4)
`ifdef PC_TRAP_EN
    , .TRAP_VECTOR(8'hF0)
`endif
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .En(En), .Branch_take(Branch_take),
    .Call(Call), .Ret(Ret), .Target(Target), .Err_clr(Err_clr),
    .Data_out(Data_out), .Ras_count(Ras_count), .Ras_full(Ras_full),
    .Ras_empty(Ras_empty), .Err_ovf(Err_ovf), .Err_unf(Err_unf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, id, act, exp);
    end
  endtask

  task automatic chk_all(input int id, input logic [7:0] epc, input logic [2:0] ecnt,
                         input logic eovf, input logic eunf);
    chk("data_out",  id, 32'(Data_out),  32'(epc));
    chk("ras_count", id, 32'(Ras_count), 32'(ecnt));
    chk("ras_full",  id, 32'(Ras_full),  32'(ecnt == 3'd4));
    chk("ras_empty", id, 32'(Ras_empty), 32'(ecnt == 3'd0));
    chk("err_ovf",   id, 32'(Err_ovf),   32'(eovf));
    chk("err_unf",   id, 32'(Err_unf),   32'(eunf));
  endtask

  // drive one cycle of controls and queue the state expected after the next edge
  task automatic step(input logic en, input logic br, input logic call, input logic ret,
                      input logic clr, input logic [7:0] tgt, input logic [7:0] epc,
                      input logic [2:0] ecnt, input logic eovf, input logic eunf);
    exp_t e;
    @(negedge CLK);
    En = en; Branch_take = br; Call = call; Ret = ret; Err_clr = clr; Target = tgt;
    step_id++;
    e.pc = epc; e.cnt = ecnt; e.ovf = eovf; e.unf = eunf; e.id = step_id;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [7:0] epc, input logic [2:0] ecnt, input logic eovf,
                      input logic eunf);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, epc, ecnt, eovf, eunf);
  endtask

  // monitor: after each rising edge, compare against the oldest queued expectation
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_all(e.id, e.pc, e.cnt, e.ovf, e.unf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rets [4];
    RST_N = 1'b0; En = 1'b0; Branch_take = 1'b0; Call = 1'b0; Ret = 1'b0;
    Err_clr = 1'b0; Target = 8'h00;
    #22;
    chk_all(0, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    // sequential increment, then stall (a Call with En=0 must be ignored)
    for (int i = 1; i <= 5; i++) idle(8'(i), 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 8'h05, 3'd0, 1'b0, 1'b0);

    // call / return
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h10, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 3'd1, 1'b0, 1'b0);
    idle(8'h41, 3'd1, 1'b0, 1'b0);
    idle(8'h42, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0);

    // priority: branch beats call/ret, call beats ret
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h60, 8'h60, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 8'h80, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h90, 8'h90, 3'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h81, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h12, 3'd0, 1'b0, 1'b0);

    // fill the stack, then overflow
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h20, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h30, 3'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 3'd3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h50, 8'h50, 3'd4, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h60, TRAP ? 8'hF0 : 8'h60, 3'd4, 1'b1, 1'b0);

    // unwind: circular build lost 0x01; trap build kept the original four
    if (TRAP) begin rets[0] = 8'h41; rets[1] = 8'h31; rets[2] = 8'h21; rets[3] = 8'h01; end
    else      begin rets[0] = 8'h51; rets[1] = 8'h41; rets[2] = 8'h31; rets[3] = 8'h21; end
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, rets[i], 3'(3 - i), 1'b1, 1'b0);

    // underflow and error clearing
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, TRAP ? 8'hF0 : 8'h22, 3'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, TRAP ? 8'hF0 : 8'h22, 3'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, TRAP ? 8'hF1 : 8'h23, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, TRAP ? 8'hF0 : 8'h24, 3'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, TRAP ? 8'hF1 : 8'h25, 3'd0, 1'b0, 1'b0);

    // address wrap
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b0);
    idle(8'h00, 3'd0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a cycle
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h10, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h20, 3'd2, 1'b0, 1'b0);
    @(posedge CLK);
    #3;
    RST_N = 1'b0; En = 1'b0; Call = 1'b0;
    #1;
    chk_all(1000, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(8'h01, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, TRAP ? 8'hF0 : 8'h02, 3'd0, 1'b0, 1'b1);

    @(negedge CLK);
    En = 1'b0; Ret = 1'b0;
    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", step_id, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
